// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated four-approach phase scheduler: round-robin green service with
// fixed yellow and all-red handover, plus emergency preemption.
module traffic_phase_scheduler #(
    parameter int unsigned GREEN_MIN   = 4,
    parameter int unsigned GREEN_MAX   = 12,
    parameter int unsigned YELLOW_TIME = 3,
    parameter int unsigned ALLRED_TIME = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       emerg_req,
    input  logic [1:0] emerg_dir,
    output logic [2:0] ns_light,
    output logic [2:0] sn_light,
    output logic [2:0] ew_light,
    output logic [2:0] we_light,
    output logic [1:0] active_dir,
    output logic [1:0] phase
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        ALLRED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] GMIN_END = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_END = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_END  = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] AR_END   = CNT_W'(ALLRED_TIME - 1);
    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic [3:0]       pending, set_mask, grant_mask, others;
    logic [1:0]       dir_nxt, rot_dir, cand, pre_dir, pre_dir_nxt;
    logic             rot_found, grant, pre_flag, pre_flag_nxt, gap_out, max_out;
    logic [3:0][2:0]  lights, lights_nxt;

    // Round-robin search starting after the active approach; the active one comes last.
    always_comb begin
        rot_dir   = active_dir;
        rot_found = 1'b0;
        cand      = active_dir;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = active_dir + 2'(i);
            if (!rot_found && pending[cand]) begin
                rot_dir   = cand;
                rot_found = 1'b1;
            end
        end
    end

    assign others  = pending & ~(4'b0001 << active_dir);
    assign gap_out = (|others) && (timer >= GMIN_END) && !req[active_dir];
    assign max_out = (|others) && (timer == GMAX_END);

    always_comb begin
        state_nxt    = state;
        dir_nxt      = active_dir;
        timer_nxt    = timer;
        pre_flag_nxt = pre_flag;
        pre_dir_nxt  = pre_dir;
        grant        = 1'b0;
        unique case (state)
            IDLE: begin
                if (emerg_req) begin
                    grant   = 1'b1;
                    dir_nxt = emerg_dir;
                end else if (rot_found) begin
                    grant   = 1'b1;
                    dir_nxt = rot_dir;
                end
            end
            GREEN: begin
                // An emergency for the active approach freezes the timer and blocks handover.
                if (emerg_req) begin
                    if (emerg_dir != active_dir) begin
                        state_nxt    = YELLOW;
                        pre_flag_nxt = 1'b1;
                        pre_dir_nxt  = emerg_dir;
                    end
                end else if (gap_out || max_out) begin
                    state_nxt = YELLOW;
                end else if (timer != GMAX_END) begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end
            YELLOW: begin
                if (timer == YEL_END) state_nxt = ALLRED;
                else                  timer_nxt = timer + CNT_W'(1);
            end
            ALLRED: begin
                if (timer == AR_END) begin
                    if (emerg_req) begin
                        grant   = 1'b1;
                        dir_nxt = emerg_dir;
                    end else if (pre_flag) begin
                        grant   = 1'b1;
                        dir_nxt = pre_dir;
                    end else if (rot_found) begin
                        grant   = 1'b1;
                        dir_nxt = rot_dir;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (grant) begin
            state_nxt    = GREEN;
            pre_flag_nxt = 1'b0;
        end
        if (state_nxt != state) timer_nxt = '0;

        for (int unsigned d = 0; d < 4; d++) begin
            lights_nxt[d] = LT_RED;
            if (dir_nxt == 2'(d)) begin
                if (state_nxt == GREEN)       lights_nxt[d] = LT_GRN;
                else if (state_nxt == YELLOW) lights_nxt[d] = LT_YEL;
            end
        end
    end

    // Grant wins over a same-edge request; a held request re-latches one edge later.
    assign set_mask   = req | (emerg_req ? (4'b0001 << emerg_dir) : 4'b0000);
    assign grant_mask = grant ? (4'b0001 << dir_nxt) : 4'b0000;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            timer      <= '0;
            pending    <= '0;
            active_dir <= 2'd3;
            pre_flag   <= 1'b0;
            pre_dir    <= 2'd0;
            lights     <= {4{LT_RED}};
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            pending    <= (pending | set_mask) & ~grant_mask;
            active_dir <= dir_nxt;
            pre_flag   <= pre_flag_nxt;
            pre_dir    <= pre_dir_nxt;
            lights     <= lights_nxt;
        end
    end

    assign ns_light = lights[0];
    assign sn_light = lights[1];
    assign ew_light = lights[2];
    assign we_light = lights[3];
    assign phase    = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: expected phase transitions are queued
// with their absolute cycle and matched against transitions recorded by a monitor.
module tb_traffic_phase_scheduler;
    localparam logic [1:0] P_IDLE   = 2'd0;
    localparam logic [1:0] P_GREEN  = 2'd1;
    localparam logic [1:0] P_YELLOW = 2'd2;
    localparam logic [1:0] P_ALLRED = 2'd3;
    localparam logic [11:0] ALL_RED = 12'b100_100_100_100;
    localparam int OBS_N = 256;

    typedef struct {
        string      tag;
        int         at;
        logic [1:0] ph;
        logic [1:0] dir;
    } exp_t;

    typedef struct {
        int          at;
        logic [1:0]  ph;
        logic [1:0]  dir;
        logic [11:0] lt;
    } obs_t;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       emerg_req;
    logic [1:0] emerg_dir;
    logic [2:0] ns_light, sn_light, ew_light, we_light;
    logic [1:0] active_dir, phase;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   obs_wr = 0;
    int   obs_rd = 0;
    int   unsafe_cnt = 0;
    int   c;
    logic [1:0] prev_ph = 2'd0;
    logic [1:0] prev_dir = 2'd3;
    obs_t obs [OBS_N];
    exp_t exp_q[$];

    traffic_phase_scheduler #(
        .GREEN_MIN(4), .GREEN_MAX(12), .YELLOW_TIME(3), .ALLRED_TIME(2), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .emerg_req(emerg_req), .emerg_dir(emerg_dir),
        .ns_light(ns_light), .sn_light(sn_light), .ew_light(ew_light), .we_light(we_light),
        .active_dir(active_dir), .phase(phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] lights_of(input logic [1:0] ph, input logic [1:0] dir);
        logic [11:0] r;
        r = ALL_RED;
        for (int d = 0; d < 4; d++) begin
            if (dir == 2'(d) && ph == P_GREEN)       r[d*3 +: 3] = 3'b001;
            else if (dir == 2'(d) && ph == P_YELLOW) r[d*3 +: 3] = 3'b010;
        end
        return r;
    endfunction

    function automatic bit lights_safe(input logic [11:0] l);
        int   nonred;
        bit   ok;
        logic [2:0] s;
        nonred = 0;
        ok = 1'b1;
        for (int d = 0; d < 4; d++) begin
            s = l[d*3 +: 3];
            if (!(s === 3'b100 || s === 3'b010 || s === 3'b001)) ok = 1'b0;
            if (s !== 3'b100) nonred++;
        end
        return ok && (nonred <= 1);
    endfunction

    function automatic logic [15:0] snap();
        return {phase, active_dir, we_light, ew_light, sn_light, ns_light};
    endfunction

    // Records every change of {phase, active_dir} and any unsafe light combination.
    always @(negedge clk) begin
        if (!reset) begin
            prev_ph  = 2'd0;
            prev_dir = 2'd3;
        end else begin
            if (!lights_safe({we_light, ew_light, sn_light, ns_light})) unsafe_cnt++;
            if (phase !== prev_ph || active_dir !== prev_dir) begin
                if (obs_wr < OBS_N)
                    obs[obs_wr] = '{cyc, phase, active_dir, {we_light, ew_light, sn_light, ns_light}};
                obs_wr++;
                prev_ph  = phase;
                prev_dir = active_dir;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        reset = 1'b0;
        req = 4'b0000;
        emerg_req = 1'b0;
        emerg_dir = 2'd0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic expect_tr(input string tag, input int at, input logic [1:0] ph, input logic [1:0] dir);
        exp_q.push_back('{tag, at, ph, dir});
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic drain(input string scen);
        exp_t e;
        obs_t o;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (obs_rd < obs_wr) else begin
                errors++;
                $error("FAIL %s observed no transition, expected ph=%0d dir=%0d at cyc %0d", e.tag, e.ph, e.dir, e.at);
            end
            if (obs_rd < obs_wr) begin
                o = obs[obs_rd];
                obs_rd++;
                checks++;
                assert (o.ph === e.ph && o.dir === e.dir && o.lt === lights_of(e.ph, e.dir) && o.at == e.at) else begin
                    errors++;
                    $error("FAIL %s observed ph=%0d dir=%0d lt=%b cyc=%0d expected ph=%0d dir=%0d lt=%b cyc=%0d",
                           e.tag, o.ph, o.dir, o.lt, o.at, e.ph, e.dir, lights_of(e.ph, e.dir), e.at);
                end
            end
        end
        checks++;
        assert (obs_rd == obs_wr) else begin
            errors++;
            $error("FAIL %s_extra observed %0d unexpected transitions expected 0", scen, obs_wr - obs_rd);
            obs_rd = obs_wr;
        end
        checks++;
        assert (unsafe_cnt == 0) else begin
            errors++;
            $error("FAIL %s_safety observed %0d unsafe cycles expected 0", scen, unsafe_cnt);
        end
    endtask

    initial begin
        reset = 1'b1;
        req = 4'b0000;
        emerg_req = 1'b0;
        emerg_dir = 2'd0;
        #1 reset = 1'b0;
        tick(2);
        chk("reset_state", snap(), {P_IDLE, 2'd3, ALL_RED});
        reset = 1'b1;
        tick(1);

        // NS demand held alone: green two edges after first sample, then rests.
        c = cyc;
        req = 4'b0001;
        expect_tr("s1_ns_green", c + 2, P_GREEN, 2'd0);
        tick(22);
        chk("s1_ns_rest", snap(), {P_GREEN, 2'd0, lights_of(P_GREEN, 2'd0)});
        drain("s1");

        // Gap-out of NS to EW, then EW gap-out back to the re-latched NS demand.
        rst_pulse();
        c = cyc;
        req = 4'b0101;
        expect_tr("s2_ns_green",   c + 2,  P_GREEN,  2'd0);
        expect_tr("s2_ns_yellow",  c + 6,  P_YELLOW, 2'd0);
        expect_tr("s2_ns_allred",  c + 9,  P_ALLRED, 2'd0);
        expect_tr("s2_ew_green",   c + 11, P_GREEN,  2'd2);
        expect_tr("s2_ew_yellow",  c + 15, P_YELLOW, 2'd2);
        expect_tr("s2_ew_allred",  c + 18, P_ALLRED, 2'd2);
        expect_tr("s2_ns_green2",  c + 20, P_GREEN,  2'd0);
        tick(4);
        req = 4'b0100;
        tick(7);
        req = 4'b0000;
        tick(11);
        drain("s2");

        // Full demand: every green max-outs at 12 cycles in round-robin order.
        rst_pulse();
        c = cyc;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            expect_tr("s3_green",  c + 2 + 17*k,  P_GREEN,  2'(k));
            expect_tr("s3_yellow", c + 14 + 17*k, P_YELLOW, 2'(k));
            expect_tr("s3_allred", c + 17 + 17*k, P_ALLRED, 2'(k));
        end
        expect_tr("s3_ns_again", c + 70, P_GREEN, 2'd0);
        tick(72);
        drain("s3");

        // Emergency for SN preempts EW green, then SN holds until released.
        rst_pulse();
        c = cyc;
        req = 4'b0100;
        expect_tr("s4_ew_green",  c + 2,  P_GREEN,  2'd2);
        expect_tr("s4_ew_yellow", c + 4,  P_YELLOW, 2'd2);
        expect_tr("s4_ew_allred", c + 7,  P_ALLRED, 2'd2);
        expect_tr("s4_sn_green",  c + 9,  P_GREEN,  2'd1);
        expect_tr("s4_sn_yellow", c + 52, P_YELLOW, 2'd1);
        expect_tr("s4_sn_allred", c + 55, P_ALLRED, 2'd1);
        expect_tr("s4_ew_green2", c + 57, P_GREEN,  2'd2);
        tick(3);
        emerg_req = 1'b1;
        emerg_dir = 2'd1;
        req = 4'b1111;
        tick(37);
        chk("s4_sn_hold", snap(), {P_GREEN, 2'd1, lights_of(P_GREEN, 2'd1)});
        emerg_req = 1'b0;
        tick(18);
        drain("s4");

        // One-cycle WE pulse is served after NS min green; reset during yellow is immediate.
        rst_pulse();
        c = cyc;
        req = 4'b0001;
        expect_tr("s5_ns_green",  c + 2,  P_GREEN,  2'd0);
        expect_tr("s5_ns_yellow", c + 6,  P_YELLOW, 2'd0);
        expect_tr("s5_ns_allred", c + 9,  P_ALLRED, 2'd0);
        expect_tr("s5_we_green",  c + 11, P_GREEN,  2'd3);
        expect_tr("s5_we_yellow", c + 15, P_YELLOW, 2'd3);
        tick(3);
        req = 4'b1000;
        tick(1);
        req = 4'b0000;
        tick(12);
        chk("s5_we_yellow_now", snap(), {P_YELLOW, 2'd3, lights_of(P_YELLOW, 2'd3)});
        reset = 1'b0;
        #1;
        chk("s5_async_reset", snap(), {P_IDLE, 2'd3, ALL_RED});
        drain("s5");
        tick(1);
        reset = 1'b1;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
